// File: rtl/rand_arb8.sv
// rand_arb8: eight-requester arbiter with a pseudo-random scan start and hold-limited ownership.
// Define RAND_ARB8_LFSR_EN to replace the incrementing scan pointer with a 3-bit maximal LFSR.
module rand_arb8 #(
   parameter int MAXHOLD = 15,
   parameter int HW      = 8
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout,
   output logic [7:0] mask
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t        state_r;
   logic [2:0]    rnd_r;
   logic [2:0]    rnd_nxt_s;
   logic [HW-1:0] hold_r;
   logic [7:0]    elig_s;
   logic [2:0]    win_s;
   logic          found_s;

`ifdef RAND_ARB8_LFSR_EN
   localparam logic [2:0] RND_RST = 3'b001;
   // taps on bits 2 and 0 produce the period-7 sequence 1,3,7,6,5,2,4
   assign rnd_nxt_s = {rnd_r[1:0], rnd_r[2] ^ rnd_r[0]};
`else
   localparam logic [2:0] RND_RST = 3'b000;
   assign rnd_nxt_s = rnd_r + 3'd1;
`endif

   assign elig_s = req & ~mask;

   // winner search: first eligible index at or after rnd, wrapping modulo 8
   always_comb begin
      win_s   = 3'd0;
      found_s = 1'b0;
      for (int i = 0; i < 8; i++) begin
         win_s   = (!found_s && elig_s[rnd_r + 3'(i)]) ? (rnd_r + 3'(i)) : win_s;
         found_s = found_s | elig_s[rnd_r + 3'(i)];
      end
   end

   // scan pointer, ownership FSM, hold counter, mask and registered outputs
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         rnd_r     <= RND_RST;
         state_r   <= IDLE;
         hold_r    <= {HW{1'b0}};
         gnt       <= 8'h00;
         gnt_id    <= 3'd0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
         mask      <= 8'h00;
      end else begin
         rnd_r   <= rnd_nxt_s;
         timeout <= 1'b0;
         mask    <= mask & req;
         case (state_r)
            IDLE: begin
               if (found_s) begin
                  gnt       <= 8'h01 << win_s;
                  gnt_id    <= win_s;
                  gnt_valid <= 1'b1;
                  hold_r    <= {{(HW-1){1'b0}}, 1'b1};
                  state_r   <= BUSY;
               end else begin
                  state_r   <= IDLE;
               end
            end
            BUSY: begin
               // a dropped request wins over an expiring hold: plain release, no mask
               if (!req[gnt_id]) begin
                  gnt       <= 8'h00;
                  gnt_valid <= 1'b0;
                  state_r   <= IDLE;
               end else if (hold_r == HW'(MAXHOLD)) begin
                  gnt       <= 8'h00;
                  gnt_valid <= 1'b0;
                  timeout   <= 1'b1;
                  mask      <= (mask & req) | gnt;
                  state_r   <= IDLE;
               end else begin
                  hold_r    <= hold_r + {{(HW-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               gnt       <= 8'h00;
               gnt_valid <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule
